// File: rtl/uart_tx_if.sv
// Host-side handshake plus the shift-register control bundle of the UART TX controller.
// The host drives tx_valid/tx_data; everything else is produced by the controller.
interface uart_tx_if;
    logic       tx_valid;
    logic [6:0] tx_data;
    logic       tx_ready;
    logic [6:0] data_out;
    logic       parity_bit;
    logic       load_data;
    logic       shift_en;
    logic       baud_tick;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, data_out, parity_bit, load_data, shift_en,
               baud_tick, tx_busy, tx_done
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, data_out, parity_bit, load_data, shift_en,
               baud_tick, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX controller: captures a 7-bit character with parity, then paces the
// downstream 10-bit shift register through exactly one frame of BAUD_DIV-cycle bits.
module uart_tx_ctrl #(
    parameter int BAUD_DIV   = 434,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);
    localparam int            CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] baud_cnt_reg;
    logic [3:0]    bit_cnt_reg;
    logic [6:0]    data_reg;
    logic          parity_reg;
    logic          load_reg;
    logic          shift_en_reg;
    logic          done_reg;
    logic          tick;
    logic          parity_next;

    // Tick is decoded from registered state so it lines up with the bit boundary.
    assign tick        = (state_reg == SEND) && (baud_cnt_reg == BAUD_LAST);
    assign parity_next = (^bus.tx_data) ^ PARITY_ODD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            data_reg     <= '0;
            parity_reg   <= 1'b0;
            load_reg     <= 1'b0;
            shift_en_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            load_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.tx_valid) begin
                        data_reg   <= bus.tx_data;
                        parity_reg <= parity_next;
                        load_reg   <= 1'b1;
                        state_reg  <= LOAD;
                    end
                end
                LOAD: begin
                    baud_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    shift_en_reg <= 1'b1;
                    state_reg    <= SEND;
                end
                SEND: begin
                    if (tick) begin
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                        // Tenth tick closes the stop bit; the frame is finished.
                        if (bit_cnt_reg == 4'd9) begin
                            shift_en_reg <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    shift_en_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready   = (state_reg == IDLE);
    assign bus.tx_busy    = (state_reg != IDLE);
    assign bus.data_out   = data_reg;
    assign bus.parity_bit = parity_reg;
    assign bus.load_data  = load_reg;
    assign bus.shift_en   = shift_en_reg;
    assign bus.baud_tick  = tick;
    assign bus.tx_done    = done_reg;
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side controller for the UART TX path, directly upstream of the 10-bit TX shift register (7 data bits, parity, start, stop).
- Accepts 7-bit characters over a valid/ready handshake and computes the parity bit.
- Generates the baud tick and drives load_data / shift_en to the shift register for exactly one 10-bit frame per character.
- Reports busy/done status to the host logic.

Parameters:
- BAUD_DIV, 434, clk cycles per bit period (50 MHz / 115200). Legal range >= 2. Counter width is clog2(BAUD_DIV).
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tx_valid  input  1  host presents a character.
- tx_data  input  7  character, sent LSB first.
- tx_ready  output  1  controller can accept; equals (state==IDLE).
- data_out  output  7  captured character, to shift register data_in.
- parity_bit  output  1  computed parity, to shift register parity_bit.
- load_data  output  1  one-cycle load strobe to the shift register.
- shift_en  output  1  high for the whole SEND state.
- baud_tick  output  1  one-cycle bit-period strobe to the shift register.
- tx_busy  output  1  state != IDLE.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (async, any state including mid-frame): state=IDLE, baud counter=0, bit counter=0, data_out=0, parity_bit=0.
  - Resulting outputs: load_data=0, shift_en=0, baud_tick=0, tx_busy=0, tx_done=0, tx_ready=1.
  - The shift register shares rst, so the line returns to idle-high. A frame interrupted by reset is abandoned and never resumed.
- FSM has three states: IDLE, LOAD, SEND.
- IDLE:
  - tx_ready=1.
  - On tx_valid=1 (accept, cycle L): register data_out<=tx_data and parity_bit<=p, then go to LOAD.
  - p = XOR of tx_data when PARITY_ODD=0, else XNOR of tx_data. The result is that the 8-bit data+parity has an even (or odd) count of ones.
  - tx_valid=0: stay in IDLE; data_out and parity_bit hold their values.
- LOAD (cycle L+1):
  - load_data=1 for exactly this cycle.
  - Baud counter and bit counter are cleared to 0.
  - Next state is SEND.
- SEND:
  - shift_en=1.
  - Baud counter increments every clk.
  - When the counter equals BAUD_DIV-1: baud_tick=1 for that cycle (decoded from registered state and counter), the counter wraps to 0, and the bit counter increments.
  - Ticks occur at cycles L+1+k*BAUD_DIV for k=1..10. The start bit is therefore driven for exactly BAUD_DIV cycles, as is every later bit.
  - On the 10th tick, the next state is IDLE. The stop bit gets a full period before the frame ends.
- tx_done: registered pulse, high in the first IDLE cycle after SEND (cycle L+2+10*BAUD_DIV), for 1 cycle.
- tx_valid while tx_busy=1: ignored, not captured. The host must hold tx_valid until it sees tx_ready.
- Back-to-back frames: a new accept is allowed in the same cycle tx_done=1. The minimum inter-frame gap on the line is 2 clk (IDLE + LOAD), during which the line stays high.
- baud_tick=0 outside SEND. The baud counter does not run in IDLE or LOAD.
- Widths:
  - Bit counter is 4 bits and is never compared beyond 10.
  - Baud counter must not overflow; it is compared for equality only.

Test Plan:
1. BAUD_DIV=4, PARITY_ODD=0: assert rst mid-simulation and hold -> all outputs at reset values, tx_ready=1; the line (shift register txd) is 1.
2. BAUD_DIV=4, even parity, send 7'h55 (accept at L):
   - load_data=1 at L+1 only; parity_bit=0.
   - baud_tick at L+5, L+9, ..., L+41; tx_done=1 at L+42.
   - txd sequence, each bit 4 cycles: 0,1,0,1,0,1,0,1,0,1.
3. Parity check, each with one frame:
   - Even parity, 7'h01 -> parity_bit=1.
   - Odd parity (PARITY_ODD=1), 7'h01 -> parity_bit=0.
   - Odd parity, 7'h00 -> parity_bit=1.
4. Hold tx_valid=1 continuously with data 7'h12 then 7'h34:
   - First accept at L; second accept exactly at L+42, while tx_done=1.
   - No char is accepted while tx_busy=1; tx_ready=0 from L+1 to L+41.
5. Assert rst at L+20 (mid data bits) -> next cycle state is IDLE, shift_en=0, no tx_done pulse.
   - After release, 7'h7F sends a full clean frame: parity_bit=1 (even); txd sequence 0,1,1,1,1,1,1,1,1,1.
6. BAUD_DIV=434 default, one frame -> exactly 10 baud_ticks, spaced 434 cycles apart; tx_busy high for 1+10*434 cycles.
